if_fetch_stage: RTL

- Instruction-fetch stage of the pipelined CPU: owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Feeds the decode stage directly downstream.
- Brings the PC to a defined start address on a real synchronous reset, with a configurable post-reset hold, so benches no longer force PC state.
- Handles stall and branch redirect (flush) from the later stages.

---
 rtl/if_fetch_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, post-reset hold counter and IF/ID pipeline register.
// Redirect outranks stall; the hold window ignores stall and only lets redirect steer the PC.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter logic [3:0]  HOLD_CYCLES = 4'd2,
   parameter logic [31:0] NOP_INSTR   = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_target,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic [31:0] fetch_count
);

   logic [63:0] pc;
   logic [3:0]  hold_cnt;

   logic [63:0] pc_next;
   logic [3:0]  hold_next;
   logic [63:0] if_pc_next;
   logic [31:0] if_instr_next;
   logic        if_valid_next;
   logic [31:0] fetch_count_next;
   logic [63:0] target_aligned;

   assign imem_addr      = pc;
   assign target_aligned = redirect_target & ~64'h3;

   // Next-state selection: HOLD phase first, then redirect > stall > advance.
   always_comb begin
      pc_next          = pc;
      hold_next        = hold_cnt;
      if_pc_next       = if_pc;
      if_instr_next    = if_instr;
      if_valid_next    = if_valid;
      fetch_count_next = fetch_count;
      if (hold_cnt != 4'd0) begin
         hold_next     = hold_cnt - 4'd1;
         if_valid_next = 1'b0;
         if_instr_next = NOP_INSTR;
         if (redirect) begin
            pc_next = target_aligned;
         end else begin
            pc_next = pc;
         end
      end else if (redirect) begin
         pc_next       = target_aligned;
         if_valid_next = 1'b0;
         if_instr_next = NOP_INSTR;
      end else if (stall) begin
         pc_next = pc;
      end else begin
         if_pc_next       = pc;
         if_instr_next    = imem_instr;
         if_valid_next    = 1'b1;
         pc_next          = pc + 64'd4;
         fetch_count_next = fetch_count + 32'd1;
      end
   end

   // State register with synchronous active-low reset overriding stall and redirect.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         hold_cnt    <= HOLD_CYCLES;
         if_pc       <= 64'h0;
         if_instr    <= NOP_INSTR;
         if_valid    <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         pc          <= pc_next;
         hold_cnt    <= hold_next;
         if_pc       <= if_pc_next;
         if_instr    <= if_instr_next;
         if_valid    <= if_valid_next;
         fetch_count <= fetch_count_next;
      end
   end

endmodule
